ps2_mouse_ctrl: RTL and testbench
=================================

# ps2_mouse_ctrl

PS/2 mouse host controller that sequences the PS/2 transmitter and consumes bytes from the PS/2 receiver. After reset it runs the device initialisation sequence: reset, self-test check, sample-rate set, then stream enable. Each step has a timeout and bounded retries. Once initialised, it forwards received movement bytes upstream and lets one upstream requester send single command bytes with acknowledge checking. It sits between `ps2_tx`/`ps2_rx` and the cursor/input logic of the sand game.

## Interface
- `ACK_TIMEOUT`, 2_000_000 — cycles allowed from `tx_done_i` to an acknowledge byte.
- `BAT_TIMEOUT`, 100_000_000 — cycles allowed for each self-test byte (`AA`, `00`) after the reset acknowledge.
- `MAX_RETRY`, 3 — transmissions of one byte allowed before entering ERROR.
- `SAMPLE_RATE`, 8'd100 — byte sent after the set-sample-rate command.

Ports:
- `clk_i` in 1 — sole clock.
- `reset_ni` in 1 — reset; asynchronous, active-low.
- `restart_i` in 1 — synchronous pulse; restarts initialisation from any state.
- `tx_idle_i` in 1 — from transmitter; transmitter is idle.
- `tx_done_i` in 1 — from transmitter; one-cycle pulse when a frame is done.
- `tx_en_o` out 1 — to transmitter; one-cycle start pulse.
- `tx_data_o` out 8 — to transmitter; byte to send, stable from `tx_en_o` until `tx_done_i`.
- `rx_done_i` in 1 — from receiver; one-cycle pulse, byte valid.
- `rx_data_i` in 8 — received byte.
- `cmd_req_i` in 1 — upstream command request; held until accepted.
- `cmd_data_i` in 8 — upstream command byte.
- `cmd_ready_o` out 1 — command can be accepted (READY state, no command in progress).
- `cmd_done_o` out 1 — one-cycle pulse when a command finishes.
- `cmd_ok_o` out 1 — valid with `cmd_done_o`; 1 means `FA` was received.
- `data_valid_o` out 1 — one-cycle pulse carrying a stream byte.
- `data_o` out 8 — stream byte.
- `init_done_o` out 1 — high while in READY or a user-command state.
- `init_err_o` out 1 — high while in ERROR.

## Operation
- **States:** RST_SEND, RST_ACK, BAT_AA, BAT_ID, RATE_SEND, RATE_ACK, VAL_SEND, VAL_ACK, EN_SEND, EN_ACK, READY, USR_SEND, USR_ACK, ERROR.
- **Bytes per state:**
  - RST_SEND sends `FF`.
  - RATE_SEND sends `F3`.
  - VAL_SEND sends `SAMPLE_RATE`.
  - EN_SEND sends `F4`.
  - USR_SEND sends the latched `cmd_data_i`.
- **\*_SEND states:**
  - When `tx_idle_i`=1, pulse `tx_en_o` with `tx_data_o` set, then wait for `tx_done_i`.
  - On `tx_done_i`: load the timer with `ACK_TIMEOUT` and go to the matching \*_ACK state.
  - `rx_done_i` is ignored while in a \*_SEND state.
- **\*_ACK states:**
  - Byte `FA`: clear the retry count and advance.
  - Byte `FE`, any other byte, or timer expiry: increment the retry count.
    - If the count is still below `MAX_RETRY`, return to the same \*_SEND state and resend the same byte.
    - Otherwise go to ERROR.
- **Transitions:**
  - RST_ACK advances to BAT_AA. Load `BAT_TIMEOUT` on entering BAT_AA and again on entering BAT_ID.
  - BAT_AA requires `AA` then goes to BAT_ID. BAT_ID requires `00` then goes to RATE_SEND.
  - In BAT_AA and BAT_ID, a wrong byte or timeout counts as a retry of `FF` and returns to RST_SEND.
  - Chain: RATE_ACK → VAL_SEND, VAL_ACK → EN_SEND, EN_ACK → READY.
- **READY:**
  - Every `rx_done_i` produces `data_valid_o`=1 and `data_o`=`rx_data_i` in the next cycle.
  - When `cmd_req_i` and `cmd_ready_o` are both high, latch `cmd_data_i` and go to USR_SEND.
- **USR_ACK:**
  - `FA` → pulse `cmd_done_o` with `cmd_ok_o`=1, return to READY.
  - Failure (wrong byte or timeout) → retry under the same rule as other \*_ACK states.
  - When the retry limit is exhausted: pulse `cmd_done_o` with `cmd_ok_o`=0 and go to ERROR.
- **ERROR:** stays there until `restart_i`.
- **`restart_i`:** in any state, go to RST_SEND in the next cycle and clear the retry count and timer. `restart_i` has priority over every other event.

## Timing
- **Reset values:** state RST_SEND; all outputs 0; `tx_data_o`=`00`; retry count 0; timer 0.
- **Transmit start:** `tx_en_o` is registered, asserted in the cycle after entry to a \*_SEND state with `tx_idle_i`=1, and lasts exactly one cycle per transmission.
- **Response latency:** acknowledge byte to state advance is 1 cycle. `data_valid_o` comes 1 cycle after `rx_done_i`.
- **Timer:** counts down once per cycle; expiry is reaching 0. If `rx_done_i` arrives in the same cycle as expiry, the byte wins.
- **Retry count:** width `$clog2(MAX_RETRY+1)`; saturates, never wraps.
- **Timer width:** `$clog2(BAT_TIMEOUT+1)`; it is shared by all ack and self-test waits.
- **Arbitration:** in READY, `cmd_ready_o` is combinational; a request accepted in cycle N gives `tx_en_o` in cycle N+2 at the earliest. Stream bytes are not forwarded in USR_SEND or USR_ACK; those bytes are treated as acknowledge candidates.

## Structure
- `ps2_pkg` holds:
  - the state enum `ps2_ctrl_state_t`;
  - the constants `PS2_CMD_RESET`=`FF`, `PS2_CMD_SET_RATE`=`F3`, `PS2_CMD_ENABLE`=`F4`, `PS2_ACK`=`FA`, `PS2_RESEND`=`FE`, `PS2_BAT_OK`=`AA`, `PS2_MOUSE_ID`=`00`.
- One sub-module, `ps2_timeout`: a loadable down-counter with inputs `load_i`, `value_i` and output `expired_o`.

## Test plan
- **Clean initialisation:** a device model answers `FF`→`FA`,`AA`,`00`; `F3`→`FA`; `64`→`FA`; `F4`→`FA`. Required: `tx_data_o` sequence `FF`,`F3`,`64`,`F4`, then `init_done_o`=1 with no retries.
- **Resend:** the first answer to `F3` is `FE`, the second is `FA`. Required: `F3` is transmitted twice and initialisation completes.
- **Silent device:** the device never answers (use `ACK_TIMEOUT`=100 in the test). Required: 3 transmissions of `FF` spaced by the timeout, then `init_err_o`=1. A `restart_i` pulse then gives RST_SEND and a new `FF`.
- **Stream and command:** in READY, rx bytes `08`,`05`,`FD` → three `data_valid_o` pulses with those values. Then a command request `F5` answered with `FA` → `cmd_done_o`=1, `cmd_ok_o`=1.
- **Self-test failure:** the device sends `FC` instead of `AA`. Required: retry from RST_SEND. `reset_ni` asserted during VAL_SEND → all outputs 0 and `FF` resent after release.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: controller states, PS/2 protocol byte codes and state-graph helpers
// shared by the mouse host controller.
package ps2_pkg;

    typedef enum logic [3:0] {
        RST_SEND, RST_ACK, BAT_AA, BAT_ID,
        RATE_SEND, RATE_ACK, VAL_SEND, VAL_ACK,
        EN_SEND, EN_ACK, READY, USR_SEND, USR_ACK, ERROR
    } ps2_ctrl_state_t;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_ACK          = 8'hFA;
    localparam logic [7:0] PS2_RESEND       = 8'hFE;
    localparam logic [7:0] PS2_BAT_OK       = 8'hAA;
    localparam logic [7:0] PS2_MOUSE_ID     = 8'h00;

    function automatic logic is_send(ps2_ctrl_state_t s);
        return s inside {RST_SEND, RATE_SEND, VAL_SEND, EN_SEND, USR_SEND};
    endfunction

    // States that wait for one device byte under the shared timer.
    function automatic logic is_wait(ps2_ctrl_state_t s);
        return s inside {RST_ACK, BAT_AA, BAT_ID, RATE_ACK, VAL_ACK, EN_ACK, USR_ACK};
    endfunction

    function automatic logic [7:0] expect_byte(ps2_ctrl_state_t s);
        return (s == BAT_AA) ? PS2_BAT_OK : (s == BAT_ID) ? PS2_MOUSE_ID : PS2_ACK;
    endfunction

    function automatic ps2_ctrl_state_t ack_state(ps2_ctrl_state_t s);
        case (s)
            RST_SEND:  return RST_ACK;
            RATE_SEND: return RATE_ACK;
            VAL_SEND:  return VAL_ACK;
            EN_SEND:   return EN_ACK;
            default:   return USR_ACK;
        endcase
    endfunction

    function automatic ps2_ctrl_state_t pass_state(ps2_ctrl_state_t s);
        case (s)
            RST_ACK:  return BAT_AA;
            BAT_AA:   return BAT_ID;
            BAT_ID:   return RATE_SEND;
            RATE_ACK: return VAL_SEND;
            VAL_ACK:  return EN_SEND;
            default:  return READY;
        endcase
    endfunction

    // Self-test failures count against the reset byte, so they resend FF.
    function automatic ps2_ctrl_state_t fail_state(ps2_ctrl_state_t s);
        case (s)
            RST_ACK, BAT_AA, BAT_ID: return RST_SEND;
            RATE_ACK: return RATE_SEND;
            VAL_ACK:  return VAL_SEND;
            EN_ACK:   return EN_SEND;
            default:  return USR_SEND;
        endcase
    endfunction

endpackage

// File: rtl/ps2_timeout.sv
// ps2_timeout: loadable down-counter that stops at zero; expired_o is high
// while the count is zero.
module ps2_timeout #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == '0);

    always_comb cnt_d = load_i ? value_i : (expired_o ? cnt_q : cnt_q - W'(1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// ps2_mouse_ctrl: PS/2 mouse host sequencer - runs reset/self-test/rate/enable
// initialisation with retries, then forwards stream bytes and user commands.
module ps2_mouse_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 2_000_000,
    parameter int unsigned BAT_TIMEOUT = 100_000_000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter logic [7:0]  SAMPLE_RATE = 8'd100
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       restart_i,
    input  logic       tx_idle_i,
    input  logic       tx_done_i,
    output logic       tx_en_o,
    output logic [7:0] tx_data_o,
    input  logic       rx_done_i,
    input  logic [7:0] rx_data_i,
    input  logic       cmd_req_i,
    input  logic [7:0] cmd_data_i,
    output logic       cmd_ready_o,
    output logic       cmd_done_o,
    output logic       cmd_ok_o,
    output logic       data_valid_o,
    output logic [7:0] data_o,
    output logic       init_done_o,
    output logic       init_err_o
);

    localparam int TW = $clog2(BAT_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    ps2_ctrl_state_t state_q, state_d;
    logic [RW-1:0]   retry_q, retry_d, retry_inc;
    logic            sent_q, sent_d;
    logic            tx_en_q, tx_en_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [7:0]      cmd_q, cmd_d;
    logic            data_valid_q, data_valid_d;
    logic [7:0]      data_q, data_d;
    logic            cmd_done_q, cmd_done_d;
    logic            cmd_ok_q, cmd_ok_d;
    logic            tmr_load, tmr_exp;
    logic [TW-1:0]   tmr_val;
    logic [7:0]      send_byte;

    ps2_timeout #(.W(TW)) u_timeout (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .load_i    (tmr_load),
        .value_i   (tmr_val),
        .expired_o (tmr_exp)
    );

    assign send_byte = (state_q == RST_SEND)  ? PS2_CMD_RESET    :
                       (state_q == RATE_SEND) ? PS2_CMD_SET_RATE :
                       (state_q == VAL_SEND)  ? SAMPLE_RATE      :
                       (state_q == EN_SEND)   ? PS2_CMD_ENABLE   : cmd_q;
    assign retry_inc = (retry_q == RW'(MAX_RETRY)) ? retry_q : retry_q + RW'(1);

    assign tx_en_o      = tx_en_q;
    assign tx_data_o    = tx_data_q;
    assign cmd_done_o   = cmd_done_q;
    assign cmd_ok_o     = cmd_ok_q;
    assign data_valid_o = data_valid_q;
    assign data_o       = data_q;
    assign cmd_ready_o  = (state_q == READY) && !restart_i;
    assign init_done_o  = state_q inside {READY, USR_SEND, USR_ACK};
    assign init_err_o   = (state_q == ERROR);

    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        sent_d       = sent_q;
        tx_en_d      = 1'b0;
        tx_data_d    = tx_data_q;
        cmd_d        = cmd_q;
        data_valid_d = 1'b0;
        data_d       = data_q;
        cmd_done_d   = 1'b0;
        cmd_ok_d     = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        if (restart_i) begin
            state_d  = RST_SEND;
            retry_d  = '0;
            sent_d   = 1'b0;
            tmr_load = 1'b1;
        end else if (is_send(state_q)) begin
            // sent_q makes the start pulse one-shot per visit to a send state
            if (!sent_q && tx_idle_i) begin
                tx_en_d   = 1'b1;
                sent_d    = 1'b1;
                tx_data_d = send_byte;
            end else if (sent_q && tx_done_i) begin
                state_d  = ack_state(state_q);
                sent_d   = 1'b0;
                tmr_load = 1'b1;
                tmr_val  = TW'(ACK_TIMEOUT);
            end
        end else if (is_wait(state_q) && (rx_done_i || tmr_exp)) begin
            if (rx_done_i && rx_data_i == expect_byte(state_q)) begin
                state_d    = pass_state(state_q);
                retry_d    = '0;
                cmd_done_d = (state_q == USR_ACK);
                cmd_ok_d   = (state_q == USR_ACK);
                if (state_d inside {BAT_AA, BAT_ID}) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(BAT_TIMEOUT);
                end
            end else begin
                retry_d    = retry_inc;
                state_d    = (retry_inc < RW'(MAX_RETRY)) ? fail_state(state_q) : ERROR;
                cmd_done_d = (state_q == USR_ACK) && (state_d == ERROR);
            end
        end else if (state_q == READY) begin
            data_valid_d = rx_done_i;
            data_d       = rx_done_i ? rx_data_i : data_q;
            if (cmd_req_i) begin
                cmd_d   = cmd_data_i;
                state_d = USR_SEND;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= RST_SEND;
            retry_q      <= '0;
            sent_q       <= 1'b0;
            tx_en_q      <= 1'b0;
            tx_data_q    <= '0;
            cmd_q        <= '0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
            cmd_done_q   <= 1'b0;
            cmd_ok_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            sent_q       <= sent_d;
            tx_en_q      <= tx_en_d;
            tx_data_q    <= tx_data_d;
            cmd_q        <= cmd_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            cmd_done_q   <= cmd_done_d;
            cmd_ok_q     <= cmd_ok_d;
        end
    end

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// tb_ps2_mouse_ctrl: randomized bench with a scripted PS/2 mouse model; expected
// byte sequences come from the protocol rules, not from the controller's FSM.
module tb_ps2_mouse_ctrl;

    localparam int ACK_TO = 100;
    localparam int BAT_TO = 400;
    localparam int MAXR   = 3;
    localparam logic [7:0] RATE = 8'd100;

    logic       clk = 1'b0;
    logic       reset_ni, restart_i, tx_idle_i, tx_done_i, tx_en_o;
    logic [7:0] tx_data_o;
    logic       rx_done_i;
    logic [7:0] rx_data_i;
    logic       cmd_req_i;
    logic [7:0] cmd_data_i;
    logic       cmd_ready_o, cmd_done_o, cmd_ok_o, data_valid_o;
    logic [7:0] data_o;
    logic       init_done_o, init_err_o;

    int vec = 0, err = 0, cyc = 0;
    logic [7:0] txlog[$], rxq[$], dvlog[$];
    int         txcyc[$], donecyc[$], rxcyc[$], dvcyc[$];
    logic       cdlog[$];
    int         nak_left[256];
    int         bat_bad = 0;
    bit         silent = 0, nak_junk = 0;
    logic [7:0] dev_b;

    ps2_mouse_ctrl #(
        .ACK_TIMEOUT(ACK_TO), .BAT_TIMEOUT(BAT_TO), .MAX_RETRY(MAXR), .SAMPLE_RATE(RATE)
    ) dut (
        .clk_i(clk), .reset_ni(reset_ni), .restart_i(restart_i),
        .tx_idle_i(tx_idle_i), .tx_done_i(tx_done_i), .tx_en_o(tx_en_o), .tx_data_o(tx_data_o),
        .rx_done_i(rx_done_i), .rx_data_i(rx_data_i),
        .cmd_req_i(cmd_req_i), .cmd_data_i(cmd_data_i), .cmd_ready_o(cmd_ready_o),
        .cmd_done_o(cmd_done_o), .cmd_ok_o(cmd_ok_o),
        .data_valid_o(data_valid_o), .data_o(data_o),
        .init_done_o(init_done_o), .init_err_o(init_err_o)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
        $fatal(1);
    end

    function automatic logic [7:0] nak_byte();
        logic [7:0] j;
        if (!nak_junk) return 8'hFE;
        do j = 8'($urandom); while (j == 8'hFA);
        return j;
    endfunction

    function automatic bit q_eq(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 0;
        foreach (a[i]) if (a[i] !== b[i]) return 0;
        return 1;
    endfunction

    // Transmitter + mouse: accepts a frame, answers after the frame completes.
    initial begin
        tx_idle_i = 1'b1;
        tx_done_i = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_en_o === 1'b1) begin
                dev_b = tx_data_o;
                txlog.push_back(dev_b);
                txcyc.push_back(cyc);
                tx_idle_i = 1'b0;
                repeat ($urandom_range(3, 12)) @(negedge clk);
                tx_done_i = 1'b1;
                tx_idle_i = 1'b1;
                donecyc.push_back(cyc);
                @(negedge clk);
                tx_done_i = 1'b0;
                if (!silent) begin
                    if (nak_left[dev_b] > 0) begin
                        nak_left[dev_b]--;
                        rxq.push_back(nak_byte());
                    end else begin
                        rxq.push_back(8'hFA);
                        if (dev_b == 8'hFF) begin
                            if (bat_bad > 0) begin
                                bat_bad--;
                                rxq.push_back(8'hFC);
                            end else begin
                                rxq.push_back(8'hAA);
                                rxq.push_back(8'h00);
                            end
                        end
                    end
                end
            end
        end
    end

    // Receiver: delivers queued bytes as one-cycle pulses with random gaps.
    initial begin
        rx_done_i = 1'b0;
        rx_data_i = 8'h00;
        forever begin
            @(negedge clk);
            if (rxq.size() != 0) begin
                repeat ($urandom_range(2, 6)) @(negedge clk);
                rx_data_i = rxq.pop_front();
                rx_done_i = 1'b1;
                rxcyc.push_back(cyc);
                @(negedge clk);
                rx_done_i = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (data_valid_o === 1'b1) begin
            dvlog.push_back(data_o);
            dvcyc.push_back(cyc);
        end
        if (cmd_done_o === 1'b1) cdlog.push_back(cmd_ok_o);
    end

    task automatic do_restart(output int r);
        repeat (8) @(negedge clk);
        r = cyc;
        restart_i = 1'b1;
        @(negedge clk);
        restart_i = 1'b0;
        txlog.delete();
        txcyc.delete();
        donecyc.delete();
    endtask

    task automatic wait_init_end();
        for (int i = 0; i < 20000 && !(init_done_o === 1'b1 || init_err_o === 1'b1); i++) @(negedge clk);
    endtask

    task automatic test_reset();
        int rel;
        reset_ni = 1'b0;
        restart_i = 1'b0;
        cmd_req_i = 1'b0;
        cmd_data_i = 8'h00;
        repeat (3) @(negedge clk);
        vec++;
        if ({tx_en_o, tx_data_o, cmd_ready_o, cmd_done_o, cmd_ok_o, data_valid_o, data_o, init_done_o, init_err_o} !== 23'd0) begin
            err++;
            $display("FAIL reset_outputs: got tx_en=%b tx_data=%h rdy=%b done=%b ok=%b dv=%b data=%h init=%b err=%b, expected all 0",
                     tx_en_o, tx_data_o, cmd_ready_o, cmd_done_o, cmd_ok_o, data_valid_o, data_o, init_done_o, init_err_o);
        end
        rel = cyc;
        reset_ni = 1'b1;
        for (int i = 0; i < 50 && txlog.size() == 0; i++) @(negedge clk);
        vec++;
        if (txlog.size() == 0 || txlog[0] !== 8'hFF || txcyc[0] != rel + 1) begin
            err++;
            $display("FAIL reset_first_ff: got %0d frames (first %h at cycle %0d), expected FF at cycle %0d",
                     txlog.size(), (txlog.size() != 0) ? txlog[0] : 8'hxx, (txcyc.size() != 0) ? txcyc[0] : -1, rel + 1);
        end
    endtask

    task automatic test_clean_init();
        logic [7:0] exp[$];
        exp = '{8'hFF, 8'hF3, RATE, 8'hF4};
        wait_init_end();
        vec++;
        if (init_done_o !== 1'b1 || init_err_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            err++;
            $display("FAIL clean_init_flags: got done=%b err=%b rdy=%b, expected 1 0 1", init_done_o, init_err_o, cmd_ready_o);
        end
        vec++;
        if (!q_eq(txlog, exp)) begin
            err++;
            $display("FAIL clean_init_seq: got %p, expected %p", txlog, exp);
        end
    endtask

    task automatic test_stream();
        logic [7:0] sb[$];
        int dv0, rx0, n;
        bit ok;
        sb = '{8'h08, 8'h05, 8'hFD};
        n = $urandom_range(2, 5);
        for (int k = 0; k < n; k++) sb.push_back(8'($urandom));
        dv0 = dvlog.size();
        rx0 = rxcyc.size();
        foreach (sb[k]) rxq.push_back(sb[k]);
        for (int i = 0; i < 500 && dvlog.size() < dv0 + sb.size(); i++) @(negedge clk);
        vec++;
        if (dvlog.size() != dv0 + sb.size()) begin
            err++;
            $display("FAIL stream_count: got %0d pulses, expected %0d", dvlog.size() - dv0, sb.size());
        end else begin
            foreach (sb[k]) begin
                ok = (dvlog[dv0 + k] === sb[k]) && (dvcyc[dv0 + k] == rxcyc[rx0 + k] + 1);
                vec++;
                if (!ok) begin
                    err++;
                    $display("FAIL stream_byte%0d: got %h at cycle %0d, expected %h at cycle %0d",
                             k, dvlog[dv0 + k], dvcyc[dv0 + k], sb[k], rxcyc[rx0 + k] + 1);
                end
            end
        end
    endtask

    // Commands are issued back to back; the last one exhausts its retries.
    task automatic test_command();
        logic [7:0] b;
        logic [7:0] exp[$];
        int n, cd0, dv0, acc;
        for (int it = 0; it < 6; it++) begin
            if (it == 0) b = 8'hF5;
            else do b = 8'($urandom); while (b == 8'hFF);
            n = (it == 0) ? 0 : (it == 5) ? MAXR : $urandom_range(0, MAXR - 1);
            nak_junk = $urandom_range(0, 1);
            nak_left[b] = n;
            exp.delete();
            for (int a = 0; a < ((n < MAXR) ? n + 1 : MAXR); a++) exp.push_back(b);
            cd0 = cdlog.size();
            dv0 = dvlog.size();
            txlog.delete();
            txcyc.delete();
            cmd_data_i = b;
            cmd_req_i = 1'b1;
            vec++;
            if (cmd_ready_o !== 1'b1) begin
                err++;
                $display("FAIL cmd%0d_ready: got %b, expected 1", it, cmd_ready_o);
            end
            acc = cyc;
            @(negedge clk);
            cmd_req_i = 1'b0;
            vec++;
            if (cmd_ready_o !== 1'b0) begin
                err++;
                $display("FAIL cmd%0d_busy: got ready=%b, expected 0", it, cmd_ready_o);
            end
            for (int i = 0; i < 2000 && cdlog.size() == cd0; i++) @(negedge clk);
            vec++;
            if (cdlog.size() != cd0 + 1 || cdlog[cdlog.size() - 1] !== (n < MAXR)) begin
                err++;
                $display("FAIL cmd%0d_done: got %0d pulses (ok=%b), expected 1 with ok=%b",
                         it, cdlog.size() - cd0, (cdlog.size() > cd0) ? cdlog[cdlog.size() - 1] : 1'bx, n < MAXR);
            end
            vec++;
            if (!q_eq(txlog, exp) || txcyc[0] != acc + 2 || dvlog.size() != dv0) begin
                err++;
                $display("FAIL cmd%0d_tx: got %p first at cycle %0d, %0d forwarded, expected %p at cycle %0d, 0 forwarded",
                         it, txlog, (txcyc.size() != 0) ? txcyc[0] : -1, dvlog.size() - dv0, exp, acc + 2);
            end
            nak_left[b] = 0;
        end
        @(negedge clk);
        vec++;
        if (init_err_o !== 1'b1 || init_done_o !== 1'b0) begin
            err++;
            $display("FAIL cmd_exhaust_err: got err=%b done=%b, expected 1 0", init_err_o, init_done_o);
        end
    endtask

    task automatic test_silent();
        int r, errcyc;
        silent = 1;
        do_restart(r);
        errcyc = -1;
        for (int i = 0; i < 2000; i++) begin
            if (init_err_o === 1'b1) begin
                errcyc = cyc;
                break;
            end
            @(negedge clk);
        end
        vec++;
        if (txlog.size() != MAXR || errcyc < 0) begin
            err++;
            $display("FAIL silent_count: got %0d frames, err seen at %0d, expected %0d frames then error", txlog.size(), errcyc, MAXR);
        end else begin
            // Per retry: enter ack wait, ACK_TO countdown, leave, registered start.
            for (int k = 0; k < MAXR - 1; k++) begin
                vec++;
                if (txlog[k + 1] !== 8'hFF || txcyc[k + 1] - donecyc[k] != ACK_TO + 3) begin
                    err++;
                    $display("FAIL silent_gap%0d: got %h after %0d cycles, expected FF after %0d", k, txlog[k + 1], txcyc[k + 1] - donecyc[k], ACK_TO + 3);
                end
            end
            vec++;
            if (errcyc != donecyc[MAXR - 1] + ACK_TO + 2) begin
                err++;
                $display("FAIL silent_err_time: got cycle %0d, expected %0d", errcyc, donecyc[MAXR - 1] + ACK_TO + 2);
            end
        end
        silent = 0;
        do_restart(r);
        vec++;
        if (init_err_o !== 1'b0) begin
            err++;
            $display("FAIL restart_clears_err: got %b, expected 0", init_err_o);
        end
        for (int i = 0; i < 50 && txlog.size() == 0; i++) @(negedge clk);
        vec++;
        if (txlog.size() == 0 || txlog[0] !== 8'hFF || txcyc[0] != r + 2) begin
            err++;
            $display("FAIL restart_ff: got %0d frames (cycle %0d), expected FF at cycle %0d", txlog.size(), (txcyc.size() != 0) ? txcyc[0] : -1, r + 2);
        end
        wait_init_end();
        vec++;
        if (init_done_o !== 1'b1) begin
            err++;
            $display("FAIL restart_init: got done=%b, expected 1", init_done_o);
        end
    endtask

    task automatic test_resend();
        int r;
        logic [7:0] exp[$];
        exp = '{8'hFF, 8'hF3, 8'hF3, RATE, 8'hF4};
        nak_junk = 0;
        nak_left[8'hF3] = 1;
        do_restart(r);
        wait_init_end();
        vec++;
        if (!q_eq(txlog, exp) || init_done_o !== 1'b1) begin
            err++;
            $display("FAIL resend: got %p done=%b, expected %p done=1", txlog, init_done_o, exp);
        end
    endtask

    task automatic test_random_init();
        logic [7:0] bytes[4];
        logic [7:0] exp[$];
        int n[4];
        int r;
        bit exp_err;
        bytes = '{8'hFF, 8'hF3, RATE, 8'hF4};
        for (int it = 0; it < 8; it++) begin
            exp.delete();
            exp_err = 0;
            nak_junk = $urandom_range(0, 1);
            foreach (n[k]) begin
                n[k] = ($urandom_range(0, 5) == 0) ? MAXR : $urandom_range(0, MAXR - 1);
                nak_left[bytes[k]] = n[k];
            end
            // Each failed answer costs one transmission; MAXR of them end it.
            foreach (n[k]) if (!exp_err) begin
                for (int a = 0; a < ((n[k] < MAXR) ? n[k] + 1 : MAXR); a++) exp.push_back(bytes[k]);
                exp_err = (n[k] >= MAXR);
            end
            do_restart(r);
            wait_init_end();
            vec++;
            if (init_err_o !== exp_err || init_done_o !== !exp_err || !q_eq(txlog, exp)) begin
                err++;
                $display("FAIL rand_init%0d: got %p err=%b done=%b, expected %p err=%b", it, txlog, init_err_o, init_done_o, exp, exp_err);
            end
            foreach (bytes[k]) nak_left[bytes[k]] = 0;
        end
    endtask

    task automatic test_selftest();
        int r, nb, rel;
        logic [7:0] exp[$];
        nb = $urandom_range(1, 2);
        bat_bad = nb;
        for (int a = 0; a <= nb; a++) exp.push_back(8'hFF);
        exp.push_back(8'hF3);
        exp.push_back(RATE);
        do_restart(r);
        for (int i = 0; i < 5000 && !(txlog.size() != 0 && txlog[txlog.size() - 1] === RATE); i++) @(negedge clk);
        vec++;
        if (!q_eq(txlog, exp)) begin
            err++;
            $display("FAIL selftest_retry: got %p, expected %p", txlog, exp);
        end
        reset_ni = 1'b0;
        #1;
        vec++;
        if ({tx_en_o, tx_data_o, cmd_ready_o, cmd_done_o, cmd_ok_o, data_valid_o, data_o, init_done_o, init_err_o} !== 23'd0) begin
            err++;
            $display("FAIL midinit_reset: got tx_data=%h data=%h flags=%b, expected all 0",
                     tx_data_o, data_o, {tx_en_o, cmd_ready_o, cmd_done_o, cmd_ok_o, data_valid_o, init_done_o, init_err_o});
        end
        repeat (50) @(negedge clk);
        for (int i = 0; i < 100 && rxq.size() != 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        txlog.delete();
        txcyc.delete();
        exp = '{8'hFF, 8'hF3, RATE, 8'hF4};
        rel = cyc;
        reset_ni = 1'b1;
        wait_init_end();
        vec++;
        if (!q_eq(txlog, exp) || txcyc[0] != rel + 1 || init_done_o !== 1'b1) begin
            err++;
            $display("FAIL reset_reinit: got %p first at %0d done=%b, expected %p first at %0d", txlog, (txcyc.size() != 0) ? txcyc[0] : -1, init_done_o, exp, rel + 1);
        end
    endtask

    initial begin
        test_reset();
        test_clean_init();
        test_stream();
        test_command();
        test_silent();
        test_resend();
        test_random_init();
        test_selftest();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
